// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input and
// the buffered instruction handed to the pre-decoder.
interface instr_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;
  logic                  imem_resp_err;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic                  inst_err;
  logic                  halted;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc, inst_err, halted,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc, inst_err, halted,
    output inst_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit with a one-entry output buffer.
// Optional macro IFU_EBREAK_HALT_EN halts fetch after an ebreak is consumed.
module instr_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h8000_0000)
) (
  input logic            clk,
  input logic            rst_n,
  instr_fetch_if.master  bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pc, pc_next;
  logic                  drop, drop_next;
  logic                  load_buf;
  logic [DATA_WIDTH-1:0] buf_inst, buf_pc;
  logic                  buf_err;
  logic [DATA_WIDTH-1:0] redirect_target;

  assign redirect_target = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      buf_inst <= '0;
      buf_pc   <= '0;
      buf_err  <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      drop  <= drop_next;
      if (load_buf) begin
        buf_inst <= bus.imem_resp_data;
        buf_pc   <= pc;
        buf_err  <= bus.imem_resp_err;
      end
    end
  end

  // Redirect wins over every other event; a response owed to a stale request
  // must still be absorbed (drop flag) before the next request is issued.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop_next  = drop;
    load_buf   = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
        if (bus.redirect_valid) pc_next = redirect_target;
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pc_next = redirect_target;
          if (bus.imem_req_ready) begin
            state_next = WAIT;
            drop_next  = 1'b1;
          end
        end else if (bus.imem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_next = redirect_target;
          if (bus.imem_resp_valid) begin
            state_next = REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next = 1'b1;
          end
        end else if (bus.imem_resp_valid) begin
          if (drop) begin
            state_next = REQ;
            drop_next  = 1'b0;
          end else begin
            load_buf   = 1'b1;
            pc_next    = pc + DATA_WIDTH'(4);
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_next    = redirect_target;
          state_next = REQ;
        end else if (bus.inst_ready) begin
`ifdef IFU_EBREAK_HALT_EN
          if (buf_inst == DATA_WIDTH'(32'h0010_0073)) state_next = HALT;
          else state_next = REQ;
`else
          state_next = REQ;
`endif
        end
      end
      HALT: begin
        if (bus.redirect_valid) begin
          pc_next    = redirect_target;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (state == HOLD);
  assign bus.inst           = buf_inst;
  assign bus.inst_pc        = buf_pc;
  assign bus.inst_err       = buf_err;
`ifdef IFU_EBREAK_HALT_EN
  assign bus.halted = (state == HALT);
`else
  assign bus.halted = 1'b0;
`endif

endmodule
